// File: rtl/bias_mem_pkg.sv
// Shared constants and types for the packed bias/weight ROM readers.
// Lanes are signed 16-bit values packed eight per 128-bit word, MSB lane first.
package bias_mem_pkg;

    localparam int BIAS_LANE_WIDTH     = 16;
    localparam int BIAS_LANES_PER_WORD = 8;
    localparam int BIAS_MAX_VALUES     = 128;

    typedef logic signed [BIAS_LANE_WIDTH-1:0] lane_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FILL,
        ST_STREAM,
        ST_FINISH
    } reader_state_t;

endpackage

// File: rtl/bias_lane_unpacker.sv
// Selects one lane out of a two-word (A then B) buffer; lane 0 is the top
// lane of word A and the last lane is the bottom lane of word B.
module bias_lane_unpacker
    import bias_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int LANE_WIDTH = BIAS_LANE_WIDTH,
    parameter int SEL_WIDTH  = $clog2(2 * DATA_WIDTH / LANE_WIDTH)
) (
    input  logic [2*DATA_WIDTH-1:0]       buffer,
    input  logic [SEL_WIDTH-1:0]          lane_sel,
    output logic signed [LANE_WIDTH-1:0]  lane
);

    localparam int LANES = 2 * DATA_WIDTH / LANE_WIDTH;

    logic [LANE_WIDTH-1:0] lanes [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = buffer[2*DATA_WIDTH-1-i*LANE_WIDTH -: LANE_WIDTH];
        end
    end

    assign lane = $signed(lanes[lane_sel]);

endmodule

// File: rtl/bias_stream_reader.sv
// Read-side controller for the packed bias ROM: fetches word pairs through both
// ROM ports, prefetches the next pair while streaming, and emits one lane per beat.
module bias_stream_reader
    import bias_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 128,
    parameter int LANE_WIDTH  = BIAS_LANE_WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [COUNT_WIDTH-1:0]        num_values,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         mem_addr_a,
    output logic [ADDR_WIDTH-1:0]         mem_addr_b,
    input  logic [DATA_WIDTH-1:0]         mem_q_a,
    input  logic [DATA_WIDTH-1:0]         mem_q_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [LANE_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0]        out_index,
    output logic                          out_last
);

    localparam int LANES_PER_GROUP = 2 * DATA_WIDTH / LANE_WIDTH;
    localparam int LANE_SEL_WIDTH  = $clog2(LANES_PER_GROUP);
    localparam int GROUP_WIDTH     = ADDR_WIDTH - 1;
    localparam int MAX_COUNT       = DEPTH * DATA_WIDTH / LANE_WIDTH;
    localparam int WIDE            = COUNT_WIDTH + 2;

    localparam logic [COUNT_WIDTH-1:0]    MAX_COUNT_C = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [LANE_SEL_WIDTH-1:0] LAST_LANE   = '1;
    localparam logic [GROUP_WIDTH:0]      ONE_G       = (GROUP_WIDTH+1)'(1);
    localparam logic [GROUP_WIDTH:0]      TWO_G       = (GROUP_WIDTH+1)'(2);

    reader_state_t               state;
    logic [COUNT_WIDTH-1:0]      count;
    logic [GROUP_WIDTH-1:0]      group;
    logic [LANE_SEL_WIDTH-1:0]   lane_pos;
    logic [2*DATA_WIDTH-1:0]     active_buf;
    logic [2*DATA_WIDTH-1:0]     shadow_buf;
    logic                        shadow_valid;
    logic [1:0]                  rd_pipe;

    logic                        hs;
    logic [COUNT_WIDTH-1:0]      clamped;
    logic [WIDE-1:0]             count_wide;
    logic [GROUP_WIDTH:0]        group_ext;
    logic [GROUP_WIDTH-1:0]      group_plus1;
    logic [GROUP_WIDTH-1:0]      group_plus2;
    logic                        need_next;
    logic                        need_after_swap;
    logic                        first_is_last;
    logic                        next_is_last;
    logic [COUNT_WIDTH-1:0]      next_index;

    function automatic logic [WIDE-1:0] group_base(input logic [GROUP_WIDTH:0] grp);
        return WIDE'(grp) << LANE_SEL_WIDTH;
    endfunction

    assign hs              = out_valid & out_ready;
    assign clamped         = (num_values > MAX_COUNT_C) ? MAX_COUNT_C : num_values;
    assign count_wide      = WIDE'(count);
    assign group_ext       = {1'b0, group};
    assign group_plus1     = group + GROUP_WIDTH'(1);
    assign group_plus2     = group + GROUP_WIDTH'(2);
    assign need_next       = count_wide > group_base(group_ext + ONE_G);
    assign need_after_swap = count_wide > group_base(group_ext + TWO_G);
    assign first_is_last   = (group_base(group_ext) + WIDE'(1)) == count_wide;
    assign next_is_last    = (WIDE'(out_index) + WIDE'(2)) == count_wide;
    assign next_index      = out_index + COUNT_WIDTH'(1);

    bias_lane_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH),
        .SEL_WIDTH  (LANE_SEL_WIDTH)
    ) u_unpacker (
        .buffer   (active_buf),
        .lane_sel (lane_pos),
        .lane     (out_data)
    );

    // rd_pipe tracks an address issue through our address register and the
    // ROM's own register; its top bit marks the edge where the data is usable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_index    <= '0;
            mem_addr_a   <= '0;
            mem_addr_b   <= '0;
            count        <= '0;
            group        <= '0;
            lane_pos     <= '0;
            active_buf   <= '0;
            shadow_buf   <= '0;
            shadow_valid <= 1'b0;
            rd_pipe      <= '0;
        end else begin
            rd_pipe <= {rd_pipe[0], 1'b0};
            if (state == ST_STREAM && rd_pipe[1]) begin
                shadow_buf   <= {mem_q_a, mem_q_b};
                shadow_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        count <= clamped;
                        group <= '0;
                        if (clamped == '0) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    mem_addr_a <= {group, 1'b0};
                    mem_addr_b <= {group, 1'b1};
                    rd_pipe    <= 2'b01;
                    state      <= ST_FILL;
                end

                ST_FILL: begin
                    if (rd_pipe[1]) begin
                        active_buf <= {mem_q_a, mem_q_b};
                        lane_pos   <= '0;
                        out_valid  <= 1'b1;
                        out_index  <= COUNT_WIDTH'(group_base(group_ext));
                        out_last   <= first_is_last;
                        if (need_next) begin
                            mem_addr_a <= {group_plus1, 1'b0};
                            mem_addr_b <= {group_plus1, 1'b1};
                            rd_pipe    <= 2'b01;
                        end
                        state <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (hs) begin
                        if (out_last) begin
                            out_valid    <= 1'b0;
                            out_last     <= 1'b0;
                            shadow_valid <= 1'b0;
                            done         <= 1'b1;
                            state        <= ST_FINISH;
                        end else if (lane_pos == LAST_LANE) begin
                            group <= group_plus1;
                            // Zero-bubble swap when the prefetch has landed;
                            // otherwise fall back to a fresh fetch.
                            if (shadow_valid) begin
                                active_buf   <= shadow_buf;
                                shadow_valid <= 1'b0;
                                lane_pos     <= '0;
                                out_index    <= next_index;
                                out_last     <= next_is_last;
                                if (need_after_swap) begin
                                    mem_addr_a <= {group_plus2, 1'b0};
                                    mem_addr_b <= {group_plus2, 1'b1};
                                    rd_pipe    <= 2'b01;
                                end
                            end else begin
                                out_valid <= 1'b0;
                                state     <= ST_ISSUE;
                            end
                        end else begin
                            lane_pos  <= lane_pos + LANE_SEL_WIDTH'(1);
                            out_index <= next_index;
                            out_last  <= next_is_last;
                        end
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_stream_reader.sv
// Directed bench for bias_stream_reader: a registered dual-port ROM model whose
// lanes hold their own global index, driven through a series of read runs.
module tb_bias_stream_reader;
    import bias_mem_pkg::*;

    localparam int ADDR_WIDTH   = 4;
    localparam int DEPTH        = 16;
    localparam int DATA_WIDTH   = 128;
    localparam int LANE_WIDTH   = 16;
    localparam int COUNT_WIDTH  = 8;
    localparam int CYCLE_BUDGET = 600;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         start;
    logic [COUNT_WIDTH-1:0]       num_values;
    logic                         busy;
    logic                         done;
    logic [ADDR_WIDTH-1:0]        mem_addr_a;
    logic [ADDR_WIDTH-1:0]        mem_addr_b;
    logic [DATA_WIDTH-1:0]        mem_q_a;
    logic [DATA_WIDTH-1:0]        mem_q_b;
    logic                         out_valid;
    logic                         out_ready;
    lane_t                        out_data;
    logic [COUNT_WIDTH-1:0]       out_index;
    logic                         out_last;

    logic [DATA_WIDTH-1:0] rom [DEPTH];

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_q_a <= rom[mem_addr_a];
        mem_q_b <= rom[mem_addr_b];
    end

    bias_stream_reader #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .LANE_WIDTH  (LANE_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_values (num_values),
        .busy       (busy),
        .done       (done),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_q_a    (mem_q_a),
        .mem_q_b    (mem_q_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [63:0] zeroVector();
        return 64'({busy, done, out_valid, out_last, out_data, out_index, mem_addr_a, mem_addr_b});
    endfunction

    // One read run: ready_mode 0 keeps out_ready high, 1 uses the 1,0,0,1 pattern.
    // spam re-asserts start while busy; abort_at >= 0 resets when that index is shown.
    task automatic applyStimulus(input string name, input int n_req, input int expect_n,
                                 input int ready_mode, input bit spam, input int abort_at);
        int cyc, beats, first_valid, done_count, done_cyc, last_hs_cyc, bubbles, addr_errs, late_done;
        bit prev_stall, finished, aborted;
        logic [25:0] held;
        beats = 0; first_valid = -1; done_count = 0; done_cyc = -1; last_hs_cyc = -1;
        bubbles = 0; addr_errs = 0; late_done = 0;
        prev_stall = 0; finished = 0; aborted = 0; held = '0;

        $display("[TB] run %s: num_values=%0d", name, n_req);
        num_values = COUNT_WIDTH'(n_req);
        out_ready  = 1'b1;
        start      = 1'b1;

        for (cyc = 0; cyc < CYCLE_BUDGET && !finished; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) checkOutput({name, " busy after start"}, 64'(busy), 64'(1));
            start = spam && busy && ((cyc % 3 == 1) || done);
            if (spam) num_values = 8'd7;

            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                checkOutput({name, " busy low after done"}, 64'(busy), 64'(0));
                finished = 1;
            end
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
                checkOutput({name, " busy with done"}, 64'(busy), 64'(1));
            end
            if (mem_addr_a > 4'd14 || mem_addr_b > 4'd15) addr_errs++;
            if (prev_stall) begin
                checkOutput({name, " stall hold"}, 64'({out_valid, out_last, out_data, out_index}), 64'(held));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;

            if (!finished && abort_at >= 0 && out_valid && int'(out_index) == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput({name, " reset zeroes outputs"}, zeroVector(), 64'(0));
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    if (done) late_done++;
                end
                checkOutput({name, " no done after reset"}, 64'(late_done), 64'(0));
                checkOutput({name, " idle after reset"}, zeroVector(), 64'(0));
                rst_n = 1'b1;
                aborted = 1;
                finished = 1;
            end

            if (!finished) begin
                out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
                if (ready_mode == 0 && first_valid >= 0 && beats < expect_n && !out_valid) bubbles++;
                if (out_valid && out_ready) begin
                    checkOutput({name, " data"}, {48'b0, out_data}, 64'(beats));
                    checkOutput({name, " index"}, 64'(out_index), 64'(beats));
                    checkOutput({name, " last"}, 64'(out_last), 64'(beats == expect_n - 1));
                    if (beats == expect_n - 1) last_hs_cyc = cyc;
                    beats++;
                end
                prev_stall = out_valid && !out_ready;
                held = {out_valid, out_last, out_data, out_index};
            end
        end
        start = 1'b0;

        if (!aborted) begin
            checkOutput({name, " beat count"}, 64'(beats), 64'(expect_n));
            checkOutput({name, " done pulses"}, 64'(done_count), 64'(1));
            checkOutput({name, " done timing"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
            checkOutput({name, " first valid cycle"}, 64'(first_valid), 64'((expect_n > 0) ? 3 : -1));
            checkOutput({name, " address bound"}, 64'(addr_errs), 64'(0));
            if (ready_mode == 0) checkOutput({name, " bubbles"}, 64'(bubbles), 64'(0));
            @(posedge clk);
            #1;
            checkOutput({name, " stays idle"}, 64'({busy, out_valid, done}), 64'(0));
        end
    endtask

    initial begin
        for (int w = 0; w < DEPTH; w++) begin
            for (int p = 0; p < 8; p++) begin
                rom[w][DATA_WIDTH-1-16*p -: 16] = 16'(8 * w + p);
            end
        end
        rst_n      = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b0;
        num_values = '0;
        #1 rst_n = 1'b0;
        #3;
        checkOutput("reset state", zeroVector(), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle after reset", zeroVector(), 64'(0));

        applyStimulus("run1", 16, 16, 0, 1'b0, -1);
        applyStimulus("run2", 122, 122, 0, 1'b0, -1);
        applyStimulus("run3", 40, 40, 1, 1'b0, -1);
        applyStimulus("run4 zero", 0, 0, 0, 1'b0, -1);
        applyStimulus("run4 clamp", 200, BIAS_MAX_VALUES, 0, 1'b0, -1);
        applyStimulus("run5 spam", 30, 30, 0, 1'b1, -1);
        applyStimulus("run5 abort", 30, 30, 0, 1'b0, 10);
        applyStimulus("run5 restart", 30, 30, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
